dir_init_writer: RTL and testbench
==================================

# dir_init_writer

Initialisation write generator for the direction RAM of the Needleman-Wunsch core. While `en_init` is high it walks an index `i` from 0 to N. It uses the alternating `hit` phase from the direction-RAM phase counter to interleave writes to the first row, cell (0,i), and the first column, cell (i,0), of the (N+1)x(N+1) direction matrix. It sits between the phase counter (upstream) and the direction RAM write port (downstream), and signals `done` to the top-level controller when the border is fully written.

## Interface
- `N`, 8, sequence length; the matrix is (N+1)x(N+1), row-major, address = row*(N+1)+col.
- `ADDR_W`, $clog2((N+1)*(N+1)), direction RAM address width.
- `DIR_W`, 2, direction code width.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `en_init` input 1: initialisation enable from the controller; level, held for the whole init.
- `hit` input 1: phase from the phase counter. 0 = first-row phase, 1 = first-column phase.
- `we` output 1: direction RAM write enable.
- `addr_w` output ADDR_W: direction RAM write address.
- `dir_w` output DIR_W: direction code to write.
- `busy` output 1: high while in RUN.
- `done` output 1: high in DONE; held until `en_init` falls.

## Operation
Direction codes:
- STOP = 2'b00
- UP = 2'b01
- LEFT = 2'b10
- DIAG = 2'b11 (not produced by this block)

State machine:
- IDLE:
  - `i`=0; no writes.
  - Go to RUN when `en_init`=1 and `hit`=0. If `hit`=1, stay in IDLE (phase alignment).
- RUN, each cycle, sampling `hit`:
  - `hit`=0: issue a row write. `addr_w`=i, `dir_w`=(i==0 ? STOP : LEFT). `i` unchanged.
  - `hit`=1: issue a column write. `addr_w`=i*(N+1), `dir_w`=(i==0 ? STOP : UP).
    - If i<N: `i`<=i+1.
    - If i==N: go to DONE.
- DONE:
  - `done`=1, `we`=0.
  - Go to IDLE (`done`=0, `i`=0) when `en_init`=0.

Rules:
- Cell 0 is written twice (both phases), both times with STOP. This is intended.
- Total writes per init: 2(N+1).
- `en_init` falling in RUN aborts:
  - Next state is IDLE; no write is issued in that cycle.
  - `i` clears; `done` is not asserted.
  - The partial border is left in the RAM.
- Repeated `hit` values in RUN (two consecutive equal samples, which the upstream counter does not produce) are still honoured per cycle. A repeated 0 rewrites the same row cell. A repeated 1 advances `i` again.
- Arithmetic:
  - `i` is $clog2(N+1) bits.
  - The product i*(N+1) is computed at ADDR_W width. Its maximum, N*(N+1), is below (N+1)^2, so there is no overflow or truncation.
- `busy`=1 exactly while in RUN.

## Timing
- All outputs are registered.
- A RUN cycle sampling `hit` at edge t drives `we`/`addr_w`/`dir_w` valid after edge t+1, for one cycle each.
- Back-to-back writes: one per clock. There is no RAM back-pressure; the RAM accepts a write every cycle.
- Entry latency: the first `we` follows one clock after the first RUN sample. `en_init` rising while `hit`=0 gives IDLE->RUN at edge t+1 and the first write after t+2.
- `done` rises on the edge that carries the last write (i=N, column) into its output register, i.e. `done` and the final `we` are high in the same cycle.
- Reset values:
  - `we`=0, `addr_w`=0, `dir_w`=STOP, `busy`=0, `done`=0.
  - State IDLE, `i`=0.
- `rst` mid-run takes effect immediately, regardless of clock. After release, the block waits in IDLE for the next `en_init` with `hit`=0.

## Test plan
- **Nominal, N=4, alternating `hit` from 0:** write sequence (addr, dir) must be (0,00), (0,00), (1,10), (5,01), (2,10), (10,01), (3,10), (15,01), (4,10), (20,01). Exactly 10 `we` pulses on consecutive cycles. `done`=1 coincides with the (20,01) write.
- **Phase alignment:** `en_init` rises while `hit`=1 for 1 cycle, then alternates. The first write must be a row write (0,00) issued after `hit` returns to 0. No column write may precede it.
- **Abort:** drop `en_init` after the (2,10) write. The next cycle must have `we`=0 and `busy`=0, and `done` must never assert. Re-raising `en_init` must restart at addr 0.
- **Async reset during RUN:** assert `rst` between clock edges after 3 writes. Outputs must go to reset values before the next edge. After release, a full init must produce all 10 writes again.
- **DONE hold and release:** keep `en_init` high 5 cycles after completion. `done` must stay 1 and `we` must stay 0. Drop `en_init`: `done` must be 0 on the next cycle.
- **Parameter sweep N=1 and N=15:** N=1 gives writes (0,00), (0,00), (1,10), (2,01). N=15 gives a last address of 240 within ADDR_W=8, with 32 writes.

Source files
------------

// File: rtl/dir_init_writer.sv
// Border initialisation for the Needleman-Wunsch direction RAM: interleaves first-row and
// first-column writes on the alternating hit phase, then reports done until en_init drops.
module dir_init_writer #(
    parameter int unsigned N      = 8,
    parameter int unsigned ADDR_W = $clog2((N + 1) * (N + 1)),
    parameter int unsigned DIR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_init_i,
    input  logic              hit_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_w_o,
    output logic [DIR_W-1:0]  dir_w_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned IW = $clog2(N + 1);

    localparam logic [DIR_W-1:0]  DirStop = DIR_W'(0);
    localparam logic [DIR_W-1:0]  DirUp   = DIR_W'(1);
    localparam logic [DIR_W-1:0]  DirLeft = DIR_W'(2);
    localparam logic [IW-1:0]     ILast   = IW'(N);
    localparam logic [ADDR_W-1:0] Stride  = ADDR_W'(N + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       i_q, i_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DIR_W-1:0]    dir_q, dir_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        dir_d   = dir_q;

        case (state_q)
            StIdle: begin
                i_d = '0;
                // Only enter on the row phase so every row write pairs with its column write.
                if (en_init_i && !hit_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!en_init_i) begin
                    state_d = StIdle;
                    i_d     = '0;
                end else if (!hit_i) begin
                    we_d   = 1'b1;
                    addr_d = ADDR_W'(i_q);
                    dir_d  = (i_q == '0) ? DirStop : DirLeft;
                end else begin
                    we_d   = 1'b1;
                    addr_d = ADDR_W'(i_q) * Stride;
                    dir_d  = (i_q == '0) ? DirStop : DirUp;
                    if (i_q == ILast) begin
                        state_d = StDone;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end
            end
            StDone: begin
                if (!en_init_i) begin
                    state_d = StIdle;
                    i_d     = '0;
                end
            end
            default: begin
                state_d = StIdle;
                i_d     = '0;
            end
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            i_q     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dir_q   <= DirStop;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign we_o     = we_q;
    assign addr_w_o = addr_q;
    assign dir_w_o  = dir_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_dir_init_writer.sv
// Drives three widths (N=4, 1, 15) from one stimulus stream and checks them against a
// border-walk reference model plus literal write tables for the clean runs.
module tb_dir_init_writer;

    localparam int NK [3] = '{4, 1, 15};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic hit = 1'b0;
    bit   lit_en = 1'b1;

    logic [2:0]      d_we, d_busy, d_done;
    logic [2:0][1:0] d_dir;
    logic [2:0][7:0] d_addr;
    logic [4:0]      a4;
    logic [1:0]      a1;
    logic [7:0]      a15;

    always #5 clk = ~clk;

    dir_init_writer #(.N(4)) u_n4 (
        .clk(clk), .rst(rst), .en_init_i(en), .hit_i(hit), .we_o(d_we[0]), .addr_w_o(a4),
        .dir_w_o(d_dir[0]), .busy_o(d_busy[0]), .done_o(d_done[0])
    );
    dir_init_writer #(.N(1)) u_n1 (
        .clk(clk), .rst(rst), .en_init_i(en), .hit_i(hit), .we_o(d_we[1]), .addr_w_o(a1),
        .dir_w_o(d_dir[1]), .busy_o(d_busy[1]), .done_o(d_done[1])
    );
    dir_init_writer #(.N(15)) u_n15 (
        .clk(clk), .rst(rst), .en_init_i(en), .hit_i(hit), .we_o(d_we[2]), .addr_w_o(a15),
        .dir_w_o(d_dir[2]), .busy_o(d_busy[2]), .done_o(d_done[2])
    );

    assign d_addr[0] = {3'b000, a4};
    assign d_addr[1] = {6'b000000, a1};
    assign d_addr[2] = a15;

    // Reference: a border walk of index i, row cell i then column cell i*(N+1).
    int m_i [3]    = '{0, 0, 0};
    int m_wc [3]   = '{0, 0, 0};
    bit m_act [3]  = '{0, 0, 0};
    bit m_fin [3]  = '{0, 0, 0};
    bit e_we [3]   = '{0, 0, 0};
    int e_addr [3] = '{0, 0, 0};
    int e_dir [3]  = '{0, 0, 0};
    int e_wc [3]   = '{0, 0, 0};

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_i[k] <= 0; m_wc[k] <= 0; m_act[k] <= 0; m_fin[k] <= 0;
                e_we[k] <= 0; e_addr[k] <= 0; e_dir[k] <= 0; e_wc[k] <= 0;
            end else begin
                e_we[k] <= 0;
                if (m_fin[k]) begin
                    if (!en) begin
                        m_fin[k] <= 0;
                        m_i[k]   <= 0;
                    end
                end else if (m_act[k]) begin
                    if (!en) begin
                        m_act[k] <= 0;
                        m_i[k]   <= 0;
                    end else begin
                        e_we[k]  <= 1;
                        e_wc[k]  <= m_wc[k];
                        m_wc[k]  <= m_wc[k] + 1;
                        if (!hit) begin
                            e_addr[k] <= m_i[k];
                            e_dir[k]  <= (m_i[k] == 0) ? 0 : 2;
                        end else begin
                            e_addr[k] <= m_i[k] * (NK[k] + 1);
                            e_dir[k]  <= (m_i[k] == 0) ? 0 : 1;
                            if (m_i[k] == NK[k]) begin
                                m_act[k] <= 0;
                                m_fin[k] <= 1;
                            end else begin
                                m_i[k] <= m_i[k] + 1;
                            end
                        end
                    end
                end else if (en && !hit) begin
                    m_act[k] <= 1;
                    m_wc[k]  <= 0;
                end
            end
        end
    end

    int tab4_a [10] = '{0, 0, 1, 5, 2, 10, 3, 15, 4, 20};
    int tab4_d [10] = '{0, 0, 2, 1, 2, 1, 2, 1, 2, 1};
    int tab1_a [4]  = '{0, 0, 1, 2};
    int tab1_d [4]  = '{0, 0, 2, 1};

    int n_total = 0;
    int n_bad   = 0;
    int dwc [3]      = '{0, 0, 0};
    bit prev_fin [3] = '{0, 0, 0};

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s n=%0d t=%0t actual=%0d required=%0d", nm, NK[k], $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("busy", k, int'(d_busy[k]), int'(m_act[k]));
            chk("done", k, int'(d_done[k]), int'(m_fin[k]));
            chk("we", k, int'(d_we[k]), int'(e_we[k]));
            if (e_we[k]) begin
                chk("addr", k, int'(d_addr[k]), e_addr[k]);
                chk("dir", k, int'(d_dir[k]), e_dir[k]);
            end
            if (rst) begin
                chk("rst_addr", k, int'(d_addr[k]), 0);
                chk("rst_dir", k, int'(d_dir[k]), 0);
            end
            if (lit_en && e_we[k] && k == 0 && e_wc[k] < 10) begin
                chk("tab4_addr", k, int'(d_addr[k]), tab4_a[e_wc[k]]);
                chk("tab4_dir", k, int'(d_dir[k]), tab4_d[e_wc[k]]);
            end
            if (lit_en && e_we[k] && k == 1 && e_wc[k] < 4) begin
                chk("tab1_addr", k, int'(d_addr[k]), tab1_a[e_wc[k]]);
                chk("tab1_dir", k, int'(d_dir[k]), tab1_d[e_wc[k]]);
            end
            if (lit_en && m_fin[k] && !prev_fin[k]) begin
                chk("done_with_we", k, int'(d_we[k]), 1);
                chk("write_count", k, dwc[k] + int'(d_we[k]), 2 * (NK[k] + 1));
                if (k == 2) chk("last_addr", k, int'(d_addr[k]), 240);
            end
            prev_fin[k] <= m_fin[k];
            if (d_we[k]) dwc[k] <= dwc[k] + 1;
            else if (!m_act[k] && !m_fin[k]) dwc[k] <= 0;
        end
    end

    task automatic drive(input bit e, input bit h);
        @(posedge clk);
        #2;
        en  = e;
        hit = h;
    endtask

    // Entry on a row phase, then the first RUN sample is also a row phase.
    task automatic init_run(input bit misalign, input int samples);
        if (misalign) drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        for (int c = 0; c < samples; c++) drive(1'b1, bit'(c % 2));
    endtask

    initial begin
        repeat (3) drive(1'b0, 1'b0);
        @(posedge clk); #2; rst = 1'b0;
        drive(1'b0, 1'b0);

        init_run(1'b0, 38);
        repeat (3) drive(1'b0, 1'b0);

        init_run(1'b1, 40);
        repeat (3) drive(1'b0, 1'b0);

        init_run(1'b0, 5);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        init_run(1'b0, 40);
        repeat (2) drive(1'b0, 1'b0);

        init_run(1'b0, 3);
        @(posedge clk); #2; rst = 1'b1; en = 1'b0; hit = 1'b0;
        repeat (2) drive(1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 1'b0);
        init_run(1'b0, 40);
        repeat (2) drive(1'b0, 1'b0);

        lit_en = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #2;
            rst = ($urandom_range(0, 199) == 0);
            if (en) en = ($urandom_range(0, 49) != 0);
            else    en = ($urandom_range(0, 4) == 0);
            hit = ($urandom_range(0, 9) == 0) ? hit : ~hit;
        end
        @(posedge clk); #2; rst = 1'b0; en = 1'b0;
        repeat (3) drive(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
